// File: rtl/tick_meter_pkg.sv
// -----------------------------------------------------------------------------
// tick_meter_pkg
//   Shared definitions for the tick period meter: FSM state encoding and the
//   default counter width / lock depth used by tick_period_meter and its
//   lock filter.
// -----------------------------------------------------------------------------
package tick_meter_pkg;

  // IDLE    : measurement disabled, counters cleared
  // ARMED   : enabled, waiting for the first tick to start a period
  // MEASURE : period counter running, each tick captures a divide value
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_LOCK_COUNT = 4;

endpackage

// File: rtl/tpm_lock_filter.sv
// -----------------------------------------------------------------------------
// tpm_lock_filter
//   Counts consecutive identical period measurements and raises o_LOCKED once
//   LOCK_COUNT of them have been seen in a row.
//
// Ports
//   i_CLK      in  1  clock, posedge
//   i_RESET    in  1  asynchronous active-high reset
//   i_CAPTURE  in  1  a new measurement is being captured this cycle
//   i_EQUAL    in  1  new measurement equals the previously captured one
//   i_CLEAR    in  1  drop match history and lock (disable / timeout)
//   o_LOCKED   out 1  LOCK_COUNT consecutive identical measurements seen
// -----------------------------------------------------------------------------
module tpm_lock_filter
  import tick_meter_pkg::*;
#(
  parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
  input  logic i_CLK,
  input  logic i_RESET,
  input  logic i_CAPTURE,
  input  logic i_EQUAL,
  input  logic i_CLEAR,
  output logic o_LOCKED
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_COUNT);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);

  logic [MW-1:0] match_reg;
  logic [MW-1:0] match_next;
  logic [MW-1:0] match_upd;
  logic          locked_reg;
  logic          locked_next;

  // A zero match count means no capture has happened since the last clear,
  // so the incoming capture is the first of a new run and starts at 1 even
  // though it is compared against a stale held value.
  always_comb begin
    if ((match_reg == '0) || !i_EQUAL) begin
      match_upd = MATCH_ONE;
    end else if (match_reg >= MATCH_MAX) begin
      match_upd = MATCH_MAX;
    end else begin
      match_upd = match_reg + MATCH_ONE;
    end
  end

  always_comb begin
    match_next  = match_reg;
    locked_next = locked_reg;
    if (i_CLEAR) begin
      match_next  = '0;
      locked_next = 1'b0;
    end else if (i_CAPTURE) begin
      match_next  = match_upd;
      locked_next = (match_upd >= MATCH_MAX);
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      match_reg  <= '0;
      locked_reg <= 1'b0;
    end else begin
      match_reg  <= match_next;
      locked_reg <= locked_next;
    end
  end

  assign o_LOCKED = locked_reg;

endmodule

// File: rtl/tick_period_meter.sv
// -----------------------------------------------------------------------------
// tick_period_meter
//   Measures the spacing of a 1-cycle tick stream and reports the divide value
//   (cycles between ticks minus 1). Flags lock after LOCK_COUNT equal
//   measurements in a row and flags a sticky timeout when the period counter
//   saturates without a tick.
//
// Ports
//   i_CLK        in  1      clock, posedge
//   i_RESET      in  1      asynchronous active-high reset
//   i_ENABLE     in  1      measurement enable; low = idle, counters cleared
//   i_TICK       in  1      tick stream, each high cycle is one event
//   o_DIV_VALUE  out WIDTH  last measured divide value
//   o_VALID      out 1      pulse: o_DIV_VALUE updated this cycle
//   o_LOCKED     out 1      LOCK_COUNT consecutive identical measurements
//   o_TIMEOUT    out 1      sticky: counter saturated with no tick
// -----------------------------------------------------------------------------
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_ENABLE,
  input  logic             i_TICK,
  output logic [WIDTH-1:0] o_DIV_VALUE,
  output logic             o_VALID,
  output logic             o_LOCKED,
  output logic             o_TIMEOUT
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] div_next;
  logic             valid_reg;
  logic             valid_next;
  logic             timeout_reg;
  logic             timeout_next;
  logic             capture;
  logic             timeout_evt;
  logic             lock_clear;
  logic             count_equal;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    div_next     = div_reg;
    valid_next   = 1'b0;
    timeout_next = timeout_reg;
    capture      = 1'b0;
    timeout_evt  = 1'b0;

    if (!i_ENABLE) begin
      // Disable wins over everything; the last divide value is kept.
      state_next   = IDLE;
      count_next   = '0;
      timeout_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A tick on the enabling cycle already starts the first period.
          count_next = '0;
          state_next = i_TICK ? MEASURE : ARMED;
        end
        ARMED: begin
          count_next = '0;
          if (i_TICK) begin
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (i_TICK) begin
            // A tick at a saturated counter is still a valid capture.
            capture      = 1'b1;
            div_next     = count_reg;
            valid_next   = 1'b1;
            timeout_next = 1'b0;
            count_next   = '0;
          end else if (count_reg == COUNT_MAX) begin
            // Saturate rather than wrap: give up on this period and re-arm.
            timeout_evt  = 1'b1;
            timeout_next = 1'b1;
            count_next   = '0;
            state_next   = ARMED;
          end else begin
            count_next = count_reg + COUNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      div_reg     <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      div_reg     <= div_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
    end
  end

  // Compared against the currently held value, i.e. the previous capture.
  assign count_equal = (count_reg == div_reg);
  assign lock_clear  = !i_ENABLE || timeout_evt;

  tpm_lock_filter #(
    .LOCK_COUNT (LOCK_COUNT)
  ) u_lock_filter (
    .i_CLK     (i_CLK),
    .i_RESET   (i_RESET),
    .i_CAPTURE (capture),
    .i_EQUAL   (count_equal),
    .i_CLEAR   (lock_clear),
    .o_LOCKED  (o_LOCKED)
  );

  assign o_DIV_VALUE = div_reg;
  assign o_VALID     = valid_reg;
  assign o_TIMEOUT   = timeout_reg;

endmodule

// File: tb/tb_tick_period_meter.sv
module tb_tick_period_meter;

  logic        clk;

  // 32-bit instance
  logic        rst_a;
  logic        en_a;
  logic        tick_a;
  logic [31:0] div_a;
  logic        valid_a;
  logic        locked_a;
  logic        timeout_a;

  // 8-bit instance for saturation behaviour
  logic        rst_b;
  logic        en_b;
  logic        tick_b;
  logic [7:0]  div_b;
  logic        valid_b;
  logic        locked_b;
  logic        timeout_b;

  int checks   = 0;
  int failures = 0;

  tick_period_meter #(.WIDTH(32), .LOCK_COUNT(4)) dut_a (
    .i_CLK       (clk),
    .i_RESET     (rst_a),
    .i_ENABLE    (en_a),
    .i_TICK      (tick_a),
    .o_DIV_VALUE (div_a),
    .o_VALID     (valid_a),
    .o_LOCKED    (locked_a),
    .o_TIMEOUT   (timeout_a)
  );

  tick_period_meter #(.WIDTH(8), .LOCK_COUNT(4)) dut_b (
    .i_CLK       (clk),
    .i_RESET     (rst_b),
    .i_ENABLE    (en_b),
    .i_TICK      (tick_b),
    .o_DIV_VALUE (div_b),
    .o_VALID     (valid_b),
    .o_LOCKED    (locked_b),
    .o_TIMEOUT   (timeout_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs for the next edge, then sample 1 time unit after it.
  task automatic step_a(input logic en, input logic tk);
    en_a   = en;
    tick_a = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic en, input logic tk);
    en_b   = en;
    tick_b = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; en_a = 1'b0; tick_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; tick_b = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({valid_a, locked_a, timeout_a} !== 3'b000 || div_a !== 32'd0) begin
      failures++;
      $display("FAIL reset_a got v/l/t=%b%b%b div=%0d exp 000 div=0", valid_a, locked_a, timeout_a, div_a);
    end
    checks++;
    if ({valid_b, locked_b, timeout_b} !== 3'b000 || div_b !== 8'd0) begin
      failures++;
      $display("FAIL reset_b got v/l/t=%b%b%b div=%0d exp 000 div=0", valid_b, locked_b, timeout_b, div_b);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    $display("reset done");
  endtask

  // Ticks every 5 cycles -> D=4, lock on 4th capture (5th tick).
  task automatic test_lock;
    int gap_bad;
    logic exp_locked;
    gap_bad = 0;
    step_a(1'b1, 1'b0);               // IDLE -> ARMED
    step_a(1'b1, 1'b1);               // first tick, no capture
    checks++;
    if (valid_a !== 1'b0) begin
      failures++;
      $display("FAIL lock_first_tick valid got=%b exp=0", valid_a);
    end
    for (int k = 2; k <= 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        step_a(1'b1, 1'b0);
        if (valid_a !== 1'b0 || timeout_a !== 1'b0) gap_bad++;
      end
      step_a(1'b1, 1'b1);
      exp_locked = (k >= 5);
      checks++;
      if ({valid_a, locked_a, timeout_a} !== {1'b1, exp_locked, 1'b0} || div_a !== 32'd4) begin
        failures++;
        $display("FAIL lock_capture%0d got v/l/t=%b%b%b div=%0d exp %b%b%b div=4",
                 k, valid_a, locked_a, timeout_a, div_a, 1'b1, exp_locked, 1'b0);
      end
      $display("lock tick %0d: div=%0d locked=%b", k, div_a, locked_a);
    end
    checks++;
    if (gap_bad != 0) begin
      failures++;
      $display("FAIL lock_gaps bad_cycles got=%0d exp=0", gap_bad);
    end
  endtask

  // Locked at 4, switch to 10-cycle period -> 9 with lock dropped, relock on 4th.
  task automatic test_period_change;
    int gap_bad;
    logic exp_locked;
    gap_bad = 0;
    for (int c = 1; c <= 4; c++) begin
      for (int j = 0; j < 9; j++) begin
        step_a(1'b1, 1'b0);
        if (valid_a !== 1'b0) gap_bad++;
      end
      step_a(1'b1, 1'b1);
      exp_locked = (c >= 4);
      checks++;
      if ({valid_a, locked_a} !== {1'b1, exp_locked} || div_a !== 32'd9) begin
        failures++;
        $display("FAIL change_capture%0d got v/l=%b%b div=%0d exp %b%b div=9",
                 c, valid_a, locked_a, div_a, 1'b1, exp_locked);
      end
      $display("change capture %0d: div=%0d locked=%b", c, div_a, locked_a);
    end
    checks++;
    if (gap_bad != 0) begin
      failures++;
      $display("FAIL change_gaps bad_cycles got=%0d exp=0", gap_bad);
    end
  endtask

  // Drop enable mid-period while locked at 9; re-enable needs two ticks.
  task automatic test_enable_drop;
    int ign_bad;
    ign_bad = 0;
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b0);
    step_a(1'b0, 1'b0);
    checks++;
    if ({valid_a, locked_a, timeout_a} !== 3'b000 || div_a !== 32'd9) begin
      failures++;
      $display("FAIL disable got v/l/t=%b%b%b div=%0d exp 000 div=9", valid_a, locked_a, timeout_a, div_a);
    end
    for (int j = 0; j < 3; j++) begin
      step_a(1'b0, 1'b1);
      if (valid_a !== 1'b0 || locked_a !== 1'b0 || div_a !== 32'd9) ign_bad++;
    end
    checks++;
    if (ign_bad != 0) begin
      failures++;
      $display("FAIL disable_ignore bad_cycles got=%0d exp=0", ign_bad);
    end
    step_a(1'b1, 1'b0);               // re-arm
    step_a(1'b1, 1'b1);               // first tick: no capture
    checks++;
    if (valid_a !== 1'b0) begin
      failures++;
      $display("FAIL reenable_first valid got=%b exp=0", valid_a);
    end
    for (int j = 0; j < 6; j++) step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b1);               // second tick, period 7 -> 6
    checks++;
    if ({valid_a, locked_a} !== 2'b10 || div_a !== 32'd6) begin
      failures++;
      $display("FAIL reenable_second got v/l=%b%b div=%0d exp 10 div=6", valid_a, locked_a, div_a);
    end
    $display("reenable capture: div=%0d locked=%b", div_a, locked_a);
  endtask

  // Tick held high -> D=0, valid every cycle from the 2nd enabled cycle.
  task automatic test_back_to_back;
    int bad;
    logic exp_locked;
    bad = 0;
    step_a(1'b0, 1'b0);
    step_a(1'b1, 1'b1);
    checks++;
    if (valid_a !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first valid got=%b exp=0", valid_a);
    end
    for (int k = 1; k <= 6; k++) begin
      step_a(1'b1, 1'b1);
      exp_locked = (k >= 4);
      checks++;
      if ({valid_a, locked_a} !== {1'b1, exp_locked} || div_a !== 32'd0) begin
        failures++;
        $display("FAIL b2b_capture%0d got v/l=%b%b div=%0d exp %b%b div=0",
                 k, valid_a, locked_a, div_a, 1'b1, exp_locked);
      end
      $display("b2b capture %0d: div=%0d locked=%b", k, div_a, locked_a);
    end
    step_a(1'b0, 1'b0);
  endtask

  // Async reset between edges mid-measurement while locked at D=3.
  task automatic test_async_reset;
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      for (int j = 0; j < 3; j++) step_a(1'b1, 1'b0);
      step_a(1'b1, 1'b1);
    end
    checks++;
    if ({valid_a, locked_a} !== 2'b11 || div_a !== 32'd3) begin
      failures++;
      $display("FAIL areset_prelock got v/l=%b%b div=%0d exp 11 div=3", valid_a, locked_a, div_a);
    end
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b0);
    #3;
    rst_a = 1'b1;
    #1;
    checks++;
    if ({valid_a, locked_a, timeout_a} !== 3'b000 || div_a !== 32'd0) begin
      failures++;
      $display("FAIL areset_immediate got v/l/t=%b%b%b div=%0d exp 000 div=0", valid_a, locked_a, timeout_a, div_a);
    end
    #2;
    rst_a = 1'b0;
    step_a(1'b1, 1'b0);               // IDLE -> ARMED
    step_a(1'b1, 1'b1);               // first tick re-arms only
    checks++;
    if (valid_a !== 1'b0 || div_a !== 32'd0) begin
      failures++;
      $display("FAIL areset_rearm got valid=%b div=%0d exp valid=0 div=0", valid_a, div_a);
    end
    for (int j = 0; j < 3; j++) step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b1);
    checks++;
    if ({valid_a, locked_a} !== 2'b10 || div_a !== 32'd3) begin
      failures++;
      $display("FAIL areset_capture got v/l=%b%b div=%0d exp 10 div=3", valid_a, locked_a, div_a);
    end
    $display("post-reset capture: div=%0d locked=%b", div_a, locked_a);
  endtask

  // WIDTH=8: lock at 4, stop ticking -> timeout at count 255; then tick at 255.
  task automatic test_timeout;
    int gap_bad;
    gap_bad = 0;
    step_b(1'b1, 1'b0);
    step_b(1'b1, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      for (int j = 0; j < 4; j++) step_b(1'b1, 1'b0);
      step_b(1'b1, 1'b1);
    end
    checks++;
    if ({valid_b, locked_b, timeout_b} !== 3'b110 || div_b !== 8'd4) begin
      failures++;
      $display("FAIL to_prelock got v/l/t=%b%b%b div=%0d exp 110 div=4", valid_b, locked_b, timeout_b, div_b);
    end
    for (int j = 0; j < 255; j++) begin
      step_b(1'b1, 1'b0);
      if (timeout_b !== 1'b0 || locked_b !== 1'b1 || valid_b !== 1'b0) gap_bad++;
    end
    checks++;
    if (gap_bad != 0) begin
      failures++;
      $display("FAIL to_early bad_cycles got=%0d exp=0", gap_bad);
    end
    step_b(1'b1, 1'b0);               // count was 255, no tick
    checks++;
    if ({valid_b, locked_b, timeout_b} !== 3'b001 || div_b !== 8'd4) begin
      failures++;
      $display("FAIL to_fire got v/l/t=%b%b%b div=%0d exp 001 div=4", valid_b, locked_b, timeout_b, div_b);
    end
    $display("timeout: timeout=%b locked=%b", timeout_b, locked_b);
    step_b(1'b1, 1'b1);               // ARMED: tick only starts a period
    checks++;
    if ({valid_b, timeout_b} !== 2'b01) begin
      failures++;
      $display("FAIL to_rearm got v/t=%b%b exp 01", valid_b, timeout_b);
    end
    for (int j = 0; j < 255; j++) step_b(1'b1, 1'b0);
    step_b(1'b1, 1'b1);               // tick exactly at count 255
    checks++;
    if ({valid_b, locked_b, timeout_b} !== 3'b100 || div_b !== 8'd255) begin
      failures++;
      $display("FAIL to_max_capture got v/l/t=%b%b%b div=%0d exp 100 div=255", valid_b, locked_b, timeout_b, div_b);
    end
    $display("max capture: div=%0d timeout=%b", div_b, timeout_b);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_period_change();
    test_enable_drop();
    test_back_to_back();
    test_async_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
